// File: rtl/sc_microsequencer_if.sv
// -----------------------------------------------------------------------------
// sc_microsequencer_if
// Bus bundle between the microsequencer and its control store / datapath.
//   master : the sequencer side (consumes MIR, IR, flags, handshakes;
//            drives CS address, datapath addresses, strobes and status)
//   slave  : the environment side (control store, datapath, memory)
// Member names follow the sequencer's external pin names.
// -----------------------------------------------------------------------------
interface sc_microsequencer_if #(
    parameter int DATAWIDTH_MIR_DIRECTION = 6,
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_CS_ADDRESS    = 11
);
    logic [40:0]                        SC_MICROSEQUENCER_MIR_InBus;
    logic [31:0]                        SC_MICROSEQUENCER_IR_InBus;
    logic [3:0]                         SC_MICROSEQUENCER_Flags_InLowBus;
    logic                               SC_MICROSEQUENCER_SetCode_In;
    logic                               SC_MICROSEQUENCER_MemReady_In;
    logic [DATAWIDTH_CS_ADDRESS-1:0]    SC_MICROSEQUENCER_CSAddress_OutBus;
    logic [DATAWIDTH_MIR_DIRECTION-1:0] SC_MICROSEQUENCER_DirA_OutBus;
    logic [DATAWIDTH_MIR_DIRECTION-1:0] SC_MICROSEQUENCER_DirB_OutBus;
    logic [DATAWIDTH_MIR_DIRECTION-1:0] SC_MICROSEQUENCER_DirC_OutBus;
    logic [2:0]                         SC_MICROSEQUENCER_Select_OutBus;
    logic                               SC_MICROSEQUENCER_RD_Out;
    logic                               SC_MICROSEQUENCER_MemRead_Out;
    logic                               SC_MICROSEQUENCER_MemWrite_Out;
    logic [DATAWIDTH_ALU_SELECTION-1:0] SC_MICROSEQUENCER_ALUOperation_OutBus;
    logic [3:0]                         SC_MICROSEQUENCER_PSR_OutBus;
    logic                               SC_MICROSEQUENCER_Commit_Out;
    logic                               SC_MICROSEQUENCER_Error_Out;

    modport master (
        input  SC_MICROSEQUENCER_MIR_InBus,
        input  SC_MICROSEQUENCER_IR_InBus,
        input  SC_MICROSEQUENCER_Flags_InLowBus,
        input  SC_MICROSEQUENCER_SetCode_In,
        input  SC_MICROSEQUENCER_MemReady_In,
        output SC_MICROSEQUENCER_CSAddress_OutBus,
        output SC_MICROSEQUENCER_DirA_OutBus,
        output SC_MICROSEQUENCER_DirB_OutBus,
        output SC_MICROSEQUENCER_DirC_OutBus,
        output SC_MICROSEQUENCER_Select_OutBus,
        output SC_MICROSEQUENCER_RD_Out,
        output SC_MICROSEQUENCER_MemRead_Out,
        output SC_MICROSEQUENCER_MemWrite_Out,
        output SC_MICROSEQUENCER_ALUOperation_OutBus,
        output SC_MICROSEQUENCER_PSR_OutBus,
        output SC_MICROSEQUENCER_Commit_Out,
        output SC_MICROSEQUENCER_Error_Out
    );

    modport slave (
        output SC_MICROSEQUENCER_MIR_InBus,
        output SC_MICROSEQUENCER_IR_InBus,
        output SC_MICROSEQUENCER_Flags_InLowBus,
        output SC_MICROSEQUENCER_SetCode_In,
        output SC_MICROSEQUENCER_MemReady_In,
        input  SC_MICROSEQUENCER_CSAddress_OutBus,
        input  SC_MICROSEQUENCER_DirA_OutBus,
        input  SC_MICROSEQUENCER_DirB_OutBus,
        input  SC_MICROSEQUENCER_DirC_OutBus,
        input  SC_MICROSEQUENCER_Select_OutBus,
        input  SC_MICROSEQUENCER_RD_Out,
        input  SC_MICROSEQUENCER_MemRead_Out,
        input  SC_MICROSEQUENCER_MemWrite_Out,
        input  SC_MICROSEQUENCER_ALUOperation_OutBus,
        input  SC_MICROSEQUENCER_PSR_OutBus,
        input  SC_MICROSEQUENCER_Commit_Out,
        input  SC_MICROSEQUENCER_Error_Out
    );
endinterface

// File: rtl/sc_microsequencer.sv
// -----------------------------------------------------------------------------
// sc_microsequencer
// Microprogram sequencer: fetches a 41-bit microinstruction from the control
// store, decodes it onto the datapath address/select/ALU lines, handles memory
// handshakes, keeps the {n,z,v,c} PSR and computes the next control-store
// address from the COND field.
// Ports:
//   SC_MICROSEQUENCER_CLOCK_50     : clock, rising edge
//   SC_MICROSEQUENCER_RESET_InHigh : asynchronous active-high reset
//   bus (master)                   : MIR/IR/flags/handshake inputs and all
//                                    sequencer outputs (see sc_microsequencer_if)
// -----------------------------------------------------------------------------
module sc_microsequencer #(
    parameter int DATAWIDTH_MIR_DIRECTION = 6,
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_CS_ADDRESS    = 11
) (
    input  logic                SC_MICROSEQUENCER_CLOCK_50,
    input  logic                SC_MICROSEQUENCER_RESET_InHigh,
    sc_microsequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXEC    = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    state_t                              state_q, state_d;
    logic [40:0]                         mir_q, mir_d;
    logic [DATAWIDTH_CS_ADDRESS-1:0]     cs_addr_q, cs_addr_d;
    logic [3:0]                          psr_q, psr_d;

    logic [DATAWIDTH_CS_ADDRESS-1:0]     seq_addr_s;
    logic [DATAWIDTH_CS_ADDRESS-1:0]     next_addr_s;
    logic                                commit_s;
    logic                                unused_ir_s;

    // MIR field decode
    logic [DATAWIDTH_MIR_DIRECTION-1:0]  mir_a_s, mir_b_s, mir_c_s;
    logic                                mir_amux_s, mir_bmux_s, mir_cmux_s;
    logic                                mir_rd_s, mir_wr_s;
    logic [DATAWIDTH_ALU_SELECTION-1:0]  mir_alu_s;
    logic [2:0]                          mir_cond_s;
    logic [DATAWIDTH_CS_ADDRESS-1:0]     mir_jaddr_s;

    assign mir_a_s     = mir_q[40:35];
    assign mir_amux_s  = mir_q[34];
    assign mir_b_s     = mir_q[33:28];
    assign mir_bmux_s  = mir_q[27];
    assign mir_c_s     = mir_q[26:21];
    assign mir_cmux_s  = mir_q[20];
    assign mir_rd_s    = mir_q[19];
    assign mir_wr_s    = mir_q[18];
    assign mir_alu_s   = mir_q[17:14];
    assign mir_cond_s  = mir_q[13:11];
    assign mir_jaddr_s = mir_q[10:0];

    // IR bits that never steer the sequencer
    assign unused_ir_s = ^{bus.SC_MICROSEQUENCER_IR_InBus[29:25],
                           bus.SC_MICROSEQUENCER_IR_InBus[18:14],
                           bus.SC_MICROSEQUENCER_IR_InBus[12:0]};

    // Retire condition: register-only words in EXEC, memory words on Ready
    always_comb begin
        commit_s = 1'b0;
        if (state_q == ST_EXEC) begin
            commit_s = ~mir_rd_s & ~mir_wr_s;
        end else if (state_q == ST_MEMWAIT) begin
            commit_s = bus.SC_MICROSEQUENCER_MemReady_In;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Next-address selection; branches test the PSR as it stood before this
    // cycle's update, and the sequential address wraps naturally at 2047
    always_comb begin
        seq_addr_s  = cs_addr_q + 11'd1;
        next_addr_s = seq_addr_s;
        case (mir_cond_s)
            3'd0: next_addr_s = seq_addr_s;
            3'd1: next_addr_s = psr_q[3] ? mir_jaddr_s : seq_addr_s;
            3'd2: next_addr_s = psr_q[2] ? mir_jaddr_s : seq_addr_s;
            3'd3: next_addr_s = psr_q[1] ? mir_jaddr_s : seq_addr_s;
            3'd4: next_addr_s = psr_q[0] ? mir_jaddr_s : seq_addr_s;
            3'd5: next_addr_s = bus.SC_MICROSEQUENCER_IR_InBus[13] ? mir_jaddr_s : seq_addr_s;
            3'd6: next_addr_s = mir_jaddr_s;
            3'd7: next_addr_s = {1'b1, bus.SC_MICROSEQUENCER_IR_InBus[31:30],
                                 bus.SC_MICROSEQUENCER_IR_InBus[24:19], 2'b00};
            default: next_addr_s = seq_addr_s;
        endcase
    end

    // Datapath register next values: MIR loads in FETCH, address/PSR on commit
    always_comb begin
        mir_d     = mir_q;
        cs_addr_d = cs_addr_q;
        psr_d     = psr_q;
        if (state_q == ST_FETCH) begin
            mir_d = bus.SC_MICROSEQUENCER_MIR_InBus;
        end else begin
            mir_d = mir_q;
        end
        if (commit_s) begin
            cs_addr_d = next_addr_s;
            if (bus.SC_MICROSEQUENCER_SetCode_In) begin
                psr_d = ~bus.SC_MICROSEQUENCER_Flags_InLowBus;
            end else begin
                psr_d = psr_q;
            end
        end else begin
            cs_addr_d = cs_addr_q;
            psr_d     = psr_q;
        end
    end

    // Datapath registers: MIR, control-store address, PSR
    always_ff @(posedge SC_MICROSEQUENCER_CLOCK_50 or posedge SC_MICROSEQUENCER_RESET_InHigh) begin
        if (SC_MICROSEQUENCER_RESET_InHigh) begin
            mir_q     <= 41'd0;
            cs_addr_q <= 11'd0;
            psr_q     <= 4'd0;
        end else begin
            mir_q     <= mir_d;
            cs_addr_q <= cs_addr_d;
            psr_q     <= psr_d;
        end
    end

    // FSM state register
    always_ff @(posedge SC_MICROSEQUENCER_CLOCK_50 or posedge SC_MICROSEQUENCER_RESET_InHigh) begin
        if (SC_MICROSEQUENCER_RESET_InHigh) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; HALT is left only through reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (mir_rd_s && mir_wr_s) begin
                    state_d = ST_HALT;
                end else if (mir_rd_s || mir_wr_s) begin
                    state_d = ST_MEMWAIT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEMWAIT: begin
                if (bus.SC_MICROSEQUENCER_MemReady_In) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MEMWAIT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // FSM outputs: decoded from registered state/MIR so reset clears them at once.
    // An illegal RD=WR=1 word never raises a strobe.
    always_comb begin
        bus.SC_MICROSEQUENCER_DirA_OutBus         = 6'd0;
        bus.SC_MICROSEQUENCER_DirB_OutBus         = 6'd0;
        bus.SC_MICROSEQUENCER_DirC_OutBus         = 6'd0;
        bus.SC_MICROSEQUENCER_Select_OutBus       = 3'd0;
        bus.SC_MICROSEQUENCER_RD_Out              = 1'b0;
        bus.SC_MICROSEQUENCER_MemRead_Out         = 1'b0;
        bus.SC_MICROSEQUENCER_MemWrite_Out        = 1'b0;
        bus.SC_MICROSEQUENCER_ALUOperation_OutBus = 4'd0;
        bus.SC_MICROSEQUENCER_Error_Out           = 1'b0;
        case (state_q)
            ST_EXEC, ST_MEMWAIT: begin
                bus.SC_MICROSEQUENCER_DirA_OutBus         = mir_a_s;
                bus.SC_MICROSEQUENCER_DirB_OutBus         = mir_b_s;
                bus.SC_MICROSEQUENCER_RD_Out              = mir_rd_s;
                bus.SC_MICROSEQUENCER_ALUOperation_OutBus = mir_alu_s;
                bus.SC_MICROSEQUENCER_MemRead_Out         = mir_rd_s & ~mir_wr_s;
                bus.SC_MICROSEQUENCER_MemWrite_Out        = mir_wr_s & ~mir_rd_s;
                if (commit_s) begin
                    bus.SC_MICROSEQUENCER_DirC_OutBus   = mir_c_s;
                    bus.SC_MICROSEQUENCER_Select_OutBus = {mir_amux_s, mir_bmux_s, mir_cmux_s};
                end else begin
                    bus.SC_MICROSEQUENCER_Select_OutBus = {mir_amux_s, mir_bmux_s, 1'b0};
                end
            end
            ST_HALT:  bus.SC_MICROSEQUENCER_Error_Out = 1'b1;
            ST_FETCH: bus.SC_MICROSEQUENCER_Error_Out = 1'b0;
            default:  bus.SC_MICROSEQUENCER_Error_Out = 1'b0;
        endcase
    end

    assign bus.SC_MICROSEQUENCER_CSAddress_OutBus = cs_addr_q;
    assign bus.SC_MICROSEQUENCER_PSR_OutBus       = psr_q;
    assign bus.SC_MICROSEQUENCER_Commit_Out       = commit_s;

endmodule

// File: tb/tb_sc_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_sc_microsequencer
// Directed and random microprogram runs against a behavioural model of the
// sequencer (address, PSR and expected per-cycle outputs per microinstruction).
// -----------------------------------------------------------------------------
module tb_sc_microsequencer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [40:0] rom [0:2047];
    logic [10:0] m_addr;
    logic [3:0]  m_psr;
    bit          m_halted;

    sc_microsequencer_if bus ();

    sc_microsequencer dut (
        .SC_MICROSEQUENCER_CLOCK_50     (clk),
        .SC_MICROSEQUENCER_RESET_InHigh (rst),
        .bus                            (bus)
    );

    // control store responds to the sequencer's address
    assign bus.SC_MICROSEQUENCER_MIR_InBus = rom[bus.SC_MICROSEQUENCER_CSAddress_OutBus];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [40:0] mk(input int a, input bit am, input int b, input bit bm,
                                       input int c, input bit cm, input bit rd, input bit wr,
                                       input int alu, input int cond, input int jaddr);
        logic [40:0] w;
        w = {a[5:0], am, b[5:0], bm, c[5:0], cm, rd, wr, alu[3:0], cond[2:0], jaddr[10:0]};
        return w;
    endfunction

    // {DirA, DirB, DirC, Select, RD, MemRead, MemWrite, ALU, Commit, Error}
    function automatic logic [29:0] obs_outs();
        return {bus.SC_MICROSEQUENCER_DirA_OutBus, bus.SC_MICROSEQUENCER_DirB_OutBus,
                bus.SC_MICROSEQUENCER_DirC_OutBus, bus.SC_MICROSEQUENCER_Select_OutBus,
                bus.SC_MICROSEQUENCER_RD_Out, bus.SC_MICROSEQUENCER_MemRead_Out,
                bus.SC_MICROSEQUENCER_MemWrite_Out, bus.SC_MICROSEQUENCER_ALUOperation_OutBus,
                bus.SC_MICROSEQUENCER_Commit_Out, bus.SC_MICROSEQUENCER_Error_Out};
    endfunction

    // expected outputs while a word is active (EXEC / MEMWAIT)
    function automatic logic [29:0] exp_active(input logic [40:0] w, input bit commit);
        bit rd, wr;
        rd = w[19];
        wr = w[18];
        return {w[40:35], w[33:28], commit ? w[26:21] : 6'd0,
                w[34], w[27], commit ? w[20] : 1'b0,
                rd, rd & ~wr, wr & ~rd, w[17:14], commit, 1'b0};
    endfunction

    // branch rules of the COND field
    function automatic logic [10:0] model_next(input logic [10:0] addr, input logic [40:0] w,
                                               input logic [3:0] psr, input logic [31:0] ir);
        int   cond;
        bit   jump;
        logic [10:0] target;
        cond   = int'(w[13:11]);
        target = w[10:0];
        jump   = 1'b0;
        if (cond == 7) return {1'b1, ir[31:30], ir[24:19], 2'b00};
        if (cond == 6) jump = 1'b1;
        else if (cond == 5) jump = ir[13];
        else if (cond >= 1) jump = psr[4 - cond];   // 1:n 2:z 3:v 4:c
        return jump ? target : 11'((int'(addr) + 1) % 2048);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_outs", 64'(obs_outs()), 64'd0);
        chk("reset_cs", 64'(bus.SC_MICROSEQUENCER_CSAddress_OutBus), 64'd0);
        chk("reset_psr", 64'(bus.SC_MICROSEQUENCER_PSR_OutBus), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_addr   = 11'd0;
        m_psr    = 4'd0;
        m_halted = 1'b0;
    endtask

    // one microinstruction: k = MEMWAIT cycles before Ready (memory words only)
    task automatic run_uinstr(input int k, input bit sc, input logic [3:0] fl, input logic [31:0] ir);
        logic [40:0] w;
        bit mem, illegal;
        int strobes;
        w       = rom[m_addr];
        mem     = w[19] ^ w[18];
        illegal = w[19] & w[18];
        strobes = 0;
        bus.SC_MICROSEQUENCER_IR_InBus       = ir;
        bus.SC_MICROSEQUENCER_MemReady_In    = 1'b0;
        bus.SC_MICROSEQUENCER_SetCode_In     = 1'($urandom_range(0, 1));
        bus.SC_MICROSEQUENCER_Flags_InLowBus = 4'($urandom);
        @(negedge clk);
        chk("fetch_outs", 64'(obs_outs()), 64'd0);
        chk("fetch_cs", 64'(bus.SC_MICROSEQUENCER_CSAddress_OutBus), 64'(m_addr));
        chk("fetch_psr", 64'(bus.SC_MICROSEQUENCER_PSR_OutBus), 64'(m_psr));
        @(posedge clk);
        #1;
        if (illegal) begin
            @(negedge clk);
            chk("illegal_exec_outs", 64'(obs_outs()), 64'(exp_active(w, 1'b0)));
            @(posedge clk);
            #1;
            m_halted = 1'b1;
        end else begin
            if (mem) begin
                for (int i = 0; i <= k; i++) begin
                    bus.SC_MICROSEQUENCER_SetCode_In = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    chk("mem_wait_outs", 64'(obs_outs()), 64'(exp_active(w, 1'b0)));
                    chk("mem_wait_cs", 64'(bus.SC_MICROSEQUENCER_CSAddress_OutBus), 64'(m_addr));
                    strobes += int'(bus.SC_MICROSEQUENCER_MemRead_Out | bus.SC_MICROSEQUENCER_MemWrite_Out);
                    @(posedge clk);
                    #1;
                end
                bus.SC_MICROSEQUENCER_MemReady_In = 1'b1;
            end
            bus.SC_MICROSEQUENCER_SetCode_In     = sc;
            bus.SC_MICROSEQUENCER_Flags_InLowBus = fl;
            @(negedge clk);
            chk("commit_outs", 64'(obs_outs()), 64'(exp_active(w, 1'b1)));
            chk("commit_cs", 64'(bus.SC_MICROSEQUENCER_CSAddress_OutBus), 64'(m_addr));
            if (mem) begin
                strobes += int'(bus.SC_MICROSEQUENCER_MemRead_Out | bus.SC_MICROSEQUENCER_MemWrite_Out);
                chk("mem_strobe_cycles", 64'(strobes), 64'(k + 2));
            end
            m_addr = model_next(m_addr, w, m_psr, ir);
            if (sc) m_psr = ~fl;
            @(posedge clk);
            #1;
            bus.SC_MICROSEQUENCER_MemReady_In = 1'b0;
            bus.SC_MICROSEQUENCER_SetCode_In  = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] r;
        logic [40:0] w;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.SC_MICROSEQUENCER_IR_InBus       = 32'd0;
        bus.SC_MICROSEQUENCER_Flags_InLowBus = 4'hF;
        bus.SC_MICROSEQUENCER_SetCode_In     = 1'b0;
        bus.SC_MICROSEQUENCER_MemReady_In    = 1'b0;
        for (int i = 0; i < 2048; i++) rom[i] = 41'd0;

        // directed microprogram
        rom[0]      = mk(5, 0, 6, 0, 7, 0, 0, 0, 0, 0, 0);
        rom[1]      = mk(1, 1, 2, 1, 3, 1, 0, 0, 3, 0, 0);
        rom[2]      = mk(4, 0, 4, 0, 4, 0, 0, 0, 1, 0, 0);
        rom[3]      = mk(8, 0, 9, 1, 10, 0, 0, 0, 2, 2, 'h120);
        rom['h120]  = mk(11, 0, 12, 0, 13, 1, 0, 0, 5, 0, 0);
        rom['h121]  = mk(14, 1, 15, 0, 16, 0, 0, 0, 6, 2, 'h300);
        rom['h122]  = mk(17, 0, 18, 0, 19, 0, 0, 0, 7, 7, 0);
        rom['h60C]  = mk(20, 0, 21, 0, 9, 1, 1, 0, 8, 0, 0);
        rom['h60D]  = mk(22, 1, 23, 1, 24, 0, 0, 1, 9, 6, 'h7FF);
        rom['h7FF]  = mk(25, 0, 26, 0, 27, 0, 0, 0, 10, 0, 0);

        @(posedge clk);
        do_reset();
        run_uinstr(0, 1'b0, 4'hF, 32'd0);
        chk("first_word_next_cs", 64'(bus.SC_MICROSEQUENCER_CSAddress_OutBus), 64'd1);
        run_uinstr(0, 1'b1, 4'b0111, 32'd0);
        chk("setcode_psr", 64'(bus.SC_MICROSEQUENCER_PSR_OutBus), 64'b1000);
        run_uinstr(0, 1'b1, 4'b1011, 32'd0);
        run_uinstr(0, 1'b0, 4'hF, 32'd0);
        chk("cond2_taken", 64'(bus.SC_MICROSEQUENCER_CSAddress_OutBus), 64'h120);
        run_uinstr(0, 1'b1, 4'hF, 32'd0);
        run_uinstr(0, 1'b0, 4'hF, 32'd0);
        chk("cond2_not_taken", 64'(bus.SC_MICROSEQUENCER_CSAddress_OutBus), 64'h122);
        run_uinstr(0, 1'b0, 4'hF, 32'h8018_0000);
        chk("cond7_dispatch", 64'(bus.SC_MICROSEQUENCER_CSAddress_OutBus), 64'h60C);
        run_uinstr(2, 1'b0, 4'hF, 32'd0);
        run_uinstr(1, 1'b0, 4'hF, 32'd0);
        chk("cond6_jump", 64'(bus.SC_MICROSEQUENCER_CSAddress_OutBus), 64'h7FF);
        run_uinstr(0, 1'b0, 4'hF, 32'd0);
        chk("wrap_to_zero", 64'(bus.SC_MICROSEQUENCER_CSAddress_OutBus), 64'd0);

        // random legal microprogram
        for (int i = 0; i < 2048; i++) begin
            r = {$urandom, $urandom};
            w = r[40:0];
            if (w[19] && w[18]) w[18] = 1'b0;
            rom[i] = w;
        end
        do_reset();
        for (int n = 0; n < 150; n++) begin
            run_uinstr(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       4'($urandom), $urandom);
        end

        // illegal word halts until reset
        rom[m_addr] = mk(30, 1, 31, 1, 32, 1, 1, 1, 11, 6, 5);
        run_uinstr(0, 1'b0, 4'hF, 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.SC_MICROSEQUENCER_MemReady_In = 1'b1;
            bus.SC_MICROSEQUENCER_SetCode_In  = 1'b1;
            @(negedge clk);
            chk("halt_outs", 64'(obs_outs()), 64'd1);
            chk("halt_cs", 64'(bus.SC_MICROSEQUENCER_CSAddress_OutBus), 64'(m_addr));
            chk("halt_psr", 64'(bus.SC_MICROSEQUENCER_PSR_OutBus), 64'(m_psr));
            @(posedge clk);
            #1;
        end
        bus.SC_MICROSEQUENCER_MemReady_In = 1'b0;
        bus.SC_MICROSEQUENCER_SetCode_In  = 1'b0;
        do_reset();
        chk("halt_cleared", 64'(bus.SC_MICROSEQUENCER_Error_Out), 64'd0);

        // reset in the middle of a memory wait
        rom[0] = mk(1, 0, 2, 0, 3, 0, 1, 0, 4, 0, 0);
        rom[1] = mk(1, 0, 2, 0, 3, 0, 0, 0, 4, 0, 0);
        do_reset();
        run_uinstr(0, 1'b1, 4'b0000, 32'd0);
        rom[1] = mk(1, 0, 2, 0, 3, 0, 0, 1, 4, 0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("memwait_write_strobe", 64'(bus.SC_MICROSEQUENCER_MemWrite_Out), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_memwait_strobes", 64'({bus.SC_MICROSEQUENCER_MemRead_Out,
                                         bus.SC_MICROSEQUENCER_MemWrite_Out,
                                         bus.SC_MICROSEQUENCER_Commit_Out}), 64'd0);
        chk("rst_memwait_cs", 64'(bus.SC_MICROSEQUENCER_CSAddress_OutBus), 64'd0);
        chk("rst_memwait_psr", 64'(bus.SC_MICROSEQUENCER_PSR_OutBus), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_addr = 11'd0;
        m_psr  = 4'd0;
        run_uinstr(1, 1'b0, 4'hF, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
